// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline encodings and widths used by the write-back stage.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB bundle, ID-stage read ports and committed-write/status outputs of the write-back stage.
interface wb_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             wb_valid_in;
    logic [XLEN-1:0]  wb_alu_result_in;
    logic [XLEN-1:0]  wb_load_data_in;
    logic [XLEN-1:0]  wb_pc_plus4_in;
    logic [2:0]       wb_load_funct3_in;
    logic [4:0]       wb_rd_addr_in;
    logic             wb_reg_write_en_in;
    logic [1:0]       wb_mem_to_reg_in;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             wb_wr_en_out;
    logic [4:0]       wb_wr_addr_out;
    logic [XLEN-1:0]  wb_wr_data_out;
    logic [CNT_W-1:0] instret_out;
    logic             wb_err_out;

    modport slave (
        input  wb_valid_in, wb_alu_result_in, wb_load_data_in, wb_pc_plus4_in,
               wb_load_funct3_in, wb_rd_addr_in, wb_reg_write_en_in, wb_mem_to_reg_in,
               rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_wr_en_out, wb_wr_addr_out, wb_wr_data_out,
               instret_out, wb_err_out
    );

    modport master (
        output wb_valid_in, wb_alu_result_in, wb_load_data_in, wb_pc_plus4_in,
               wb_load_funct3_in, wb_rd_addr_in, wb_reg_write_en_in, wb_mem_to_reg_in,
               rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_wr_en_out, wb_wr_addr_out, wb_wr_data_out,
               instret_out, wb_err_out
    );

endinterface

// File: rtl/load_extend.sv
// Extracts the addressed byte/half from an aligned load word and sign/zero-extends it.
// Combinational; also flags half/word accesses that are not naturally aligned.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] value,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word[8*offset +: 8];
        half_sel   = offset[1] ? word[31:16] : word[15:0];
        value      = word;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: value = {24'b0, byte_sel};
            F3_LH: begin
                value      = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                value      = {16'b0, half_sel};
                misaligned = offset[0];
            end
            // LW and every undefined encoding behave as a full-word load
            default: misaligned = (offset != 2'b00);
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: load extension, write-back select, integer register file with
// write-through read bypass, retired-instruction counter and sticky error flag.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [XLEN-1:0]  ld_value;
    logic             ld_mis;
    logic             err_cond;
    logic             wr_en;
    logic [XLEN-1:0]  wr_data;
    logic [4:0]       wr_addr;
    logic [CNT_W-1:0] instret;
    logic             err;

    load_extend u_load_extend (
        .word       (bus.wb_load_data_in),
        .funct3     (bus.wb_load_funct3_in),
        .offset     (bus.wb_alu_result_in[1:0]),
        .value      (ld_value),
        .misaligned (ld_mis)
    );

    always_comb begin
        wr_addr  = bus.wb_rd_addr_in;
        err_cond = bus.wb_valid_in &
                   ((bus.wb_mem_to_reg_in == WB_SEL_RSVD) |
                    ((bus.wb_mem_to_reg_in == WB_SEL_LOAD) & ld_mis));
        case (bus.wb_mem_to_reg_in)
            WB_SEL_ALU:  wr_data = bus.wb_alu_result_in;
            WB_SEL_LOAD: wr_data = ld_value;
            WB_SEL_PC4:  wr_data = bus.wb_pc_plus4_in;
            default:     wr_data = '0;
        endcase
        wr_en = bus.wb_valid_in & bus.wb_reg_write_en_in & (wr_addr != 5'd0) & ~err_cond;
    end

    // Read ports see this cycle's committed write so ID never reads a stale value
    always_comb begin
        if (bus.rs1_addr == 5'd0)
            bus.rs1_data = '0;
        else if (wr_en && (bus.rs1_addr == wr_addr))
            bus.rs1_data = wr_data;
        else
            bus.rs1_data = regs[bus.rs1_addr];

        if (bus.rs2_addr == 5'd0)
            bus.rs2_data = '0;
        else if (wr_en && (bus.rs2_addr == wr_addr))
            bus.rs2_data = wr_data;
        else
            bus.rs2_data = regs[bus.rs2_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            instret <= '0;
            err     <= 1'b0;
        end else begin
            if (wr_en)
                regs[wr_addr] <= wr_data;
            if (bus.wb_valid_in && !err_cond)
                instret <= instret + CNT_W'(1);
            if (err_cond)
                err <= 1'b1;
        end
    end

    assign bus.wb_wr_en_out   = wr_en;
    assign bus.wb_wr_addr_out = wr_addr;
    assign bus.wb_wr_data_out = wr_data;
    assign bus.instret_out    = instret;
    assign bus.wb_err_out     = err;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an array/arithmetic reference model.
module tb_wb_regfile;

    logic clk;
    logic rst;
    logic rst2;
    int   checks;
    int   failures;

    wb_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();
    wb_regfile_if #(.XLEN(32), .CNT_W(4))  bus2 ();

    wb_regfile #(.NREGS(32), .CNT_W(64)) dut  (.clk(clk), .rst(rst),  .bus(bus));
    wb_regfile #(.NREGS(32), .CNT_W(4))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0]     m_regs [32];
    longint unsigned m_instret;
    logic            m_err;

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input int off);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input int off);
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        return off != 0;
    endfunction

    function automatic void m_eval(output bit wen, output logic [31:0] data, output bit errc);
        int off;
        off  = int'(bus.wb_alu_result_in % 4);
        errc = bus.wb_valid_in &&
               (bus.wb_mem_to_reg_in == 2'd3 ||
                (bus.wb_mem_to_reg_in == 2'd1 && m_mis(bus.wb_load_funct3_in, off)));
        case (bus.wb_mem_to_reg_in)
            2'd0:    data = bus.wb_alu_result_in;
            2'd1:    data = m_load(bus.wb_load_data_in, bus.wb_load_funct3_in, off);
            2'd2:    data = bus.wb_pc_plus4_in;
            default: data = 32'h0;
        endcase
        wen = bus.wb_valid_in && bus.wb_reg_write_en_in && bus.wb_rd_addr_in != 0 && !errc;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit wen, input logic [31:0] data);
        if (a == 0) return 32'h0;
        if (wen && a == bus.wb_rd_addr_in) return data;
        return m_regs[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        bit          wen;
        bit          errc;
        logic [31:0] data;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            m_instret <= 0;
            m_err     <= 1'b0;
        end else begin
            m_eval(wen, data, errc);
            if (wen) m_regs[bus.wb_rd_addr_in] <= data;
            if (bus.wb_valid_in && !errc) m_instret <= m_instret + 1;
            if (errc) m_err <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit          wen;
        bit          errc;
        logic [31:0] data;
        m_eval(wen, data, errc);
        chk("wr_en", 64'(bus.wb_wr_en_out), 64'(wen));
        if (wen) begin
            chk("wr_addr", 64'(bus.wb_wr_addr_out), 64'(bus.wb_rd_addr_in));
            chk("wr_data", 64'(bus.wb_wr_data_out), 64'(data));
        end
        chk("rs1_data", 64'(bus.rs1_data), 64'(m_read(bus.rs1_addr, wen, data)));
        chk("rs2_data", 64'(bus.rs2_data), 64'(m_read(bus.rs2_addr, wen, data)));
        chk("instret", bus.instret_out, m_instret);
        chk("err", 64'(bus.wb_err_out), 64'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic put(input bit v, input logic [1:0] m2r, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4,
                       input logic [4:0] rd, input bit we, input logic [4:0] r1, input logic [4:0] r2);
        bus.wb_valid_in        = v;
        bus.wb_mem_to_reg_in   = m2r;
        bus.wb_load_funct3_in  = f3;
        bus.wb_alu_result_in   = alu;
        bus.wb_load_data_in    = ld;
        bus.wb_pc_plus4_in     = pc4;
        bus.wb_rd_addr_in      = rd;
        bus.wb_reg_write_en_in = we;
        bus.rs1_addr           = r1;
        bus.rs2_addr           = r2;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rst2     = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus2.wb_valid_in        = 1'b0;
        bus2.wb_mem_to_reg_in   = 2'd0;
        bus2.wb_load_funct3_in  = 3'd2;
        bus2.wb_alu_result_in   = 32'h0;
        bus2.wb_load_data_in    = 32'h0;
        bus2.wb_pc_plus4_in     = 32'h0;
        bus2.wb_rd_addr_in      = 5'd0;
        bus2.wb_reg_write_en_in = 1'b0;
        bus2.rs1_addr           = 5'd0;
        bus2.rs2_addr           = 5'd0;
        repeat (2) cyc();
        chk("reset_instret", bus.instret_out, 64'd0);
        chk("reset_err", 64'(bus.wb_err_out), 64'd0);
        rst = 1'b0;
        cyc();

        // LB / LBU of byte 3 of 0x80FF7F01
        put(1, 2'd1, 3'd0, 32'h0000_1003, 32'h80FF_7F01, 0, 5, 1, 0, 0);
        #1 chk("lb_data", 64'(bus.wb_wr_data_out), 64'hFFFF_FF80);
        cyc();
        put(1, 2'd1, 3'd4, 32'h0000_1003, 32'h80FF_7F01, 0, 5, 1, 5, 0);
        #1 chk("lbu_bypass", 64'(bus.rs1_data), 64'h0000_0080);
        cyc();
        put(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        #1 chk("lbu_stored", 64'(bus.rs1_data), 64'h0000_0080);
        cyc();

        // same-cycle write-through, then write to x0
        put(1, 2'd0, 3'd0, 32'hDEAD_BEEF, 0, 0, 7, 1, 7, 0);
        #1 chk("bypass_x7", 64'(bus.rs1_data), 64'hDEAD_BEEF);
        cyc();
        put(1, 2'd0, 3'd0, 32'h0000_1234, 0, 0, 0, 1, 7, 0);
        #1 chk("x0_read", 64'(bus.rs2_data), 64'd0);
        chk("x0_no_wr", 64'(bus.wb_wr_en_out), 64'd0);
        cyc();
        chk("instret_4", bus.instret_out, 64'd4);

        // misaligned LH
        put(1, 2'd1, 3'd1, 32'h0000_2001, 32'h1234_5678, 0, 5, 1, 5, 0);
        #1 chk("mis_no_wr", 64'(bus.wb_wr_en_out), 64'd0);
        chk("mis_reg_kept", 64'(bus.rs1_data), 64'h0000_0080);
        chk("err_not_yet", 64'(bus.wb_err_out), 64'd0);
        cyc();
        put(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("err_set", 64'(bus.wb_err_out), 64'd1);
        chk("mis_no_count", bus.instret_out, 64'd4);
        cyc();
        chk("err_sticky", 64'(bus.wb_err_out), 64'd1);

        // PC+4 and ALU write-back paths
        put(1, 2'd2, 3'd0, 32'h0000_0003, 0, 32'h0000_1004, 1, 1, 0, 0);
        cyc();
        put(1, 2'd0, 3'd0, 32'h0000_55AA, 0, 0, 2, 1, 1, 0);
        #1 chk("pc4_x1", 64'(bus.rs1_data), 64'h0000_1004);
        cyc();
        put(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        #1 chk("alu_x2", 64'(bus.rs1_data), 64'h0000_55AA);

        // bubbles with write request and garbage fields
        for (int i = 0; i < 10; i++) begin
            cyc();
            put(0, 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 3, 1, 3, 0);
        end
        cyc();
        chk("bubble_x3", 64'(bus.rs1_data), 64'd0);
        chk("bubble_instret", bus.instret_out, 64'd6);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0] rd;
            int         r;
            cyc();
            rd = 5'($urandom);
            r  = int'($urandom_range(0, 31));
            put($urandom_range(0, 9) < 8,
                (r == 0) ? 2'd3 : 2'(r % 3),
                3'($urandom), $urandom, $urandom, $urandom,
                rd, ($urandom % 4) != 0,
                ($urandom % 2 == 1) ? rd : 5'($urandom), 5'($urandom));
        end

        // asynchronous reset mid-cycle
        cyc();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1 chk("arst_instret", bus.instret_out, 64'd0);
        chk("arst_err", 64'(bus.wb_err_out), 64'd0);
        for (int a = 1; a < 32; a++) begin
            bus.rs1_addr = 5'(a);
            #1 chk("arst_reg", 64'(bus.rs1_data), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            put(1, 2'd0, 3'd0, $urandom, 0, 0, 5'($urandom), 1, 5'($urandom), 5'($urandom));
        end
        cyc();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // counter wrap on a 4-bit instance
        #1 rst2 = 1'b0;
        bus2.wb_valid_in = 1'b1;
        repeat (15) @(posedge clk);
        #1 chk("wrap_max", 64'(bus2.instret_out), 64'd15);
        @(posedge clk);
        #1 chk("wrap_zero", 64'(bus2.instret_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
